// File: rtl/niosii_ocimem_pkg.sv
// Shared definitions for the OCI debug-memory controller: the FSM state
// encoding and the bit positions of the fields carried in jdo.
package niosii_ocimem_pkg;

  // Controller states; the explicit values keep the encoding stable for
  // anything that decodes the raw state bits.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WRITE   = 2'd3
  } ocimem_state_e;

  // Width of the decoded JTAG word and of a debug RAM data word.
  localparam int JDO_W         = 38;
  localparam int OCIMEM_DATA_W = 32;

  // Field positions inside jdo.
  localparam int JDO_RD_BIT      = 35;
  localparam int JDO_CLR_ERR_BIT = 33;
  localparam int JDO_ADDR_LSB    = 10;
  localparam int JDO_WDATA_LSB   = 3;

endpackage

// File: rtl/niosii_ocimem_ram.sv
// Single-port synchronous debug RAM, 2^ADDR_W words of 32 bits.
// Reads take one cycle; a write returns the new data on the same edge
// (write-first). Contents are never reset.
module niosii_ocimem_ram
  import niosii_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     we,
  input  logic [OCIMEM_DATA_W-1:0] wdata,
  output logic [OCIMEM_DATA_W-1:0] rdata
);

  logic [OCIMEM_DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Storage update and registered read port with write-first forwarding.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/niosii_cpu_debug_ocimem_ctrl.sv
// CPU-clock-side controller for the on-chip debug RAM. Turns the decoded
// JTAG strobes into address loads, auto-incrementing reads and writes, and
// reports MonDReg / monitor_ready / monitor_error back to the debug slave.
// Optional build macro NIOSII_OCIMEM_ROM_PROTECT_EN makes the top ROM_WORDS
// words of the map read-only; without it every address is writable.
module niosii_cpu_debug_ocimem_ctrl
  import niosii_ocimem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ROM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              ocimem_busy,
  output logic [ADDR_W-1:0] MonAReg
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  ocimem_state_e            state;
  ocimem_state_e            state_next;
  logic [OCIMEM_DATA_W-1:0] wdata_q;
  logic [OCIMEM_DATA_W-1:0] ram_rdata;
  logic                     ram_we;
  logic                     wr_blocked;
  logic                     any_strobe;
  logic                     unused_jdo;

  // jdo[37:36] and jdo[2:0] carry nothing for this block.
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                      take_no_action_ocimem_a;

`ifdef NIOSII_OCIMEM_ROM_PROTECT_EN
  localparam logic [ADDR_W:0] ROM_BASE = (ADDR_W+1)'((1 << ADDR_W) - ROM_WORDS);

  // Addresses at or above ROM_BASE are the read-only top of the map.
  always_comb begin
    wr_blocked = ({1'b0, MonAReg} >= ROM_BASE);
  end
`else
  logic unused_rom_words;
  assign unused_rom_words = (ROM_WORDS != 0);

  // Without protection every word is writable.
  always_comb begin
    wr_blocked = 1'b0;
  end
`endif

  // Write strobe to the RAM; reset kills a pending write in WRITE.
  assign ram_we = (state == ST_WRITE) && !wr_blocked && !reset;

  // Next-state selection; strobes are honoured only in IDLE, b > a > no_action.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (take_action_ocimem_b)
          state_next = ST_WRITE;
        else if (take_action_ocimem_a)
          state_next = jdo[JDO_RD_BIT] ? ST_READ : ST_IDLE;
        else if (take_no_action_ocimem_a)
          state_next = ST_READ;
      end
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      ST_WRITE:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register; busy is registered alongside so it mirrors the state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ocimem_busy <= 1'b0;
    end else begin
      state       <= state_next;
      ocimem_busy <= (state_next != ST_IDLE);
    end
  end

  // Address, read data, status flags and latched write data.
  always_ff @(posedge clk) begin
    if (reset) begin
      MonDReg       <= '0;
      MonAReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      wdata_q       <= '0;
    end else begin
      if ((state != ST_IDLE) && any_strobe)
        monitor_error <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (take_action_ocimem_b) begin
            monitor_ready <= 1'b0;
            wdata_q       <= jdo[JDO_WDATA_LSB +: OCIMEM_DATA_W];
          end else if (take_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            MonAReg       <= jdo[JDO_ADDR_LSB +: ADDR_W];
            if (jdo[JDO_CLR_ERR_BIT])
              monitor_error <= 1'b0;
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          MonDReg       <= ram_rdata;
          monitor_ready <= 1'b1;
          MonAReg       <= MonAReg + ADDR_ONE;
        end
        ST_WRITE: begin
          MonAReg <= MonAReg + ADDR_ONE;
          if (wr_blocked)
            monitor_error <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  niosii_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .addr  (MonAReg),
    .we    (ram_we),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_niosii_cpu_debug_ocimem_ctrl.sv
// Self-checking bench for niosii_cpu_debug_ocimem_ctrl. A transaction-level
// model (array memory, address counter, flags) predicts every output.
module tb_niosii_cpu_debug_ocimem_ctrl;

  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int ROMW  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        ocimem_busy;
  logic [AW-1:0] MonAReg;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] refMem [DEPTH];
  bit          refValid [DEPTH];
  int          refAddr;
  logic [31:0] refDreg;
  bit          refReady;
  bit          refErr;

  niosii_cpu_debug_ocimem_ctrl #(.ADDR_W(AW), .ROM_WORDS(ROMW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .ocimem_busy             (ocimem_busy),
    .MonAReg                 (MonAReg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  function automatic bit isProtected(input int a);
`ifdef NIOSII_OCIMEM_ROM_PROTECT_EN
    return a >= DEPTH - ROMW;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [37:0] randJdo();
    logic [37:0] j;
    j[31:0]  = $urandom;
    j[37:32] = 6'($urandom);
    return j;
  endfunction

  // One-cycle strobe pulse; returns at the negedge of the following cycle.
  task automatic applyStimulus(input bit a, input bit b, input bit na, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a = a;
    take_action_ocimem_b = b;
    take_no_action_ocimem_a = na;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".addr"},  32'(MonAReg), 32'(refAddr));
    checkOutput({tag, ".ready"}, 32'(monitor_ready), 32'(refReady));
    checkOutput({tag, ".err"},   32'(monitor_error), 32'(refErr));
    checkOutput({tag, ".busy"},  32'(ocimem_busy), 32'd0);
  endtask

  // Called one cycle after a read strobe; follows READ and CAPTURE.
  task automatic readTail(input string tag);
    checkOutput({tag, ".busyRd"}, 32'(ocimem_busy), 32'd1);
    @(negedge clk);
    checkOutput({tag, ".readyEarly"}, 32'(monitor_ready), 32'd0);
    @(negedge clk);
    refReady = 1'b1;
    if (refValid[refAddr]) begin
      refDreg = refMem[refAddr];
      checkOutput({tag, ".data"}, MonDReg, refDreg);
    end
    refAddr = (refAddr + 1) % DEPTH;
    checkAll(tag);
  endtask

  task automatic opLoad(input string tag, input int a, input bit rd, input bit clr);
    logic [37:0] j;
    j = randJdo();
    j[17:10] = 8'(a);
    j[35] = rd;
    j[33] = clr;
    applyStimulus(1'b1, 1'b0, 1'b0, j);
    refAddr  = a;
    refReady = 1'b0;
    if (clr) refErr = 1'b0;
    if (rd) readTail(tag);
    else checkAll(tag);
  endtask

  task automatic opNext(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b1, randJdo());
    refReady = 1'b0;
    readTail(tag);
  endtask

  task automatic modelWrite(input logic [31:0] d);
    if (isProtected(refAddr)) refErr = 1'b1;
    else begin
      refMem[refAddr]   = d;
      refValid[refAddr] = 1'b1;
    end
    refAddr = (refAddr + 1) % DEPTH;
  endtask

  task automatic opWrite(input string tag, input logic [31:0] d);
    logic [37:0] j;
    j = randJdo();
    j[34:3] = d;
    applyStimulus(1'b0, 1'b1, 1'b0, j);
    refReady = 1'b0;
    checkOutput({tag, ".busyWr"}, 32'(ocimem_busy), 32'd1);
    @(negedge clk);
    modelWrite(d);
    checkAll(tag);
  endtask

  initial begin
    logic [37:0] j;
    for (int i = 0; i < DEPTH; i++) refValid[i] = 1'b0;
    refAddr = 0; refDreg = '0; refReady = 1'b0; refErr = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;

    // Reset held for two cycles.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst.dreg",  MonDReg, 32'd0);
    checkAll("rst");
    reset = 1'b0;

    // Address load without read, then write and read back.
    opLoad("load12", 'h12, 1'b0, 1'b0);
    opWrite("wrBeef", 32'hDEADBEEF);
    opLoad("rdBeef", 'h12, 1'b1, 1'b0);

    // Address wrap on a sequential read.
    opLoad("loadFF", 'hFF, 1'b0, 1'b0);
    opNext("wrapRd");

    // Collision: second read strobe while the first is in flight.
    opLoad("load12b", 'h12, 1'b0, 1'b0);
    @(negedge clk);
    jdo = randJdo();
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    @(negedge clk);
    refReady = 1'b1;
    refDreg  = refMem['h12];
    refAddr  = 'h13;
    refErr   = 1'b1;
    checkOutput("collide.data", MonDReg, refDreg);
    checkAll("collide");
    opLoad("clrErr", 'h20, 1'b0, 1'b1);

    // Simultaneous a and b strobes: the write wins, the load is ignored.
    j = randJdo();
    applyStimulus(1'b1, 1'b1, 1'b0, j);
    refReady = 1'b0;
    @(negedge clk);
    modelWrite(j[34:3]);
    checkAll("prio");
    opLoad("prioRd", 'h20, 1'b1, 1'b0);

    // Fill the whole map with random words.
    opLoad("fill", 0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) opWrite("fillWr", $urandom);
    opLoad("fillClr", 0, 1'b0, 1'b1);

    // Write to the first word of the top 64.
    opLoad("loadC0", 'hC0, 1'b0, 1'b0);
    opWrite("wrC0", 32'h55);
    opLoad("rdC0", 'hC0, 1'b1, 1'b0);
`ifdef NIOSII_OCIMEM_ROM_PROTECT_EN
    checkOutput("romKept", 32'(MonDReg == 32'h55), 32'd0);
`endif

    // Reset asserted while the FSM sits in WRITE.
    opLoad("preRst", 'h12, 1'b0, 1'b0);
    j = randJdo();
    j[34:3] = 32'h0BADF00D;
    applyStimulus(1'b0, 1'b1, 1'b0, j);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    refAddr = 0; refDreg = '0; refReady = 1'b0; refErr = 1'b0;
    checkOutput("midRst.dreg", MonDReg, 32'd0);
    checkAll("midRst");
    opLoad("postRst", 'h12, 1'b1, 1'b0);

    // Randomized mix of loads, reads and writes.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          opLoad("rndLd", $urandom_range(0, DEPTH-1), 1'b0, 1'($urandom));
          opWrite("rndWr", $urandom);
        end
        1: opLoad("rndRd", $urandom_range(0, DEPTH-1), 1'b1, 1'($urandom));
        default: opNext("rndNext");
      endcase
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
